// File: rtl/tea_decrypt_iter_if.sv
// Handshake bundle for the iterative TEA decryption core:
// a ciphertext/key input channel and a plaintext output channel.
interface tea_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  idata;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  odata;

    modport master (
        output in_valid, idata, key, out_ready,
        input  in_ready, out_valid, odata
    );

    modport slave (
        input  in_valid, idata, key, out_ready,
        output in_ready, out_valid, odata
    );
endinterface

// File: rtl/tea_decrypt_iter.sv
// Iterative TEA decryption: one inverse round per clock, ROUNDS cycles per block,
// with the key latched at acceptance and the plaintext held until taken downstream.
module tea_decrypt_iter #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E37_79B9
) (
    input  logic               clk,
    input  logic               rst_n,
    tea_decrypt_iter_if.slave  bus
);

    localparam int unsigned         CNT_W     = $clog2(ROUNDS + 1);
    localparam logic [63:0]         SUM_FULL  = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0]         SUM_INIT  = SUM_FULL[31:0];
    localparam logic [CNT_W-1:0]    CNT_INIT  = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [31:0]        y_q,         y_d;
    logic [31:0]        z_q,         z_d;
    logic [31:0]        sum_q,       sum_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [127:0]       key_q,       key_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        odata_q,     odata_d;
    logic               in_ready_q,  in_ready_d;
    logic [31:0]        z_new_s;
    logic [31:0]        y_new_s;

    // Feistel mixing term shared by both halves of a round.
    function automatic logic [31:0] tea_mix(
        input logic [31:0] v,
        input logic [31:0] ka,
        input logic [31:0] kb,
        input logic [31:0] s
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // Next-state, datapath round and output computation.
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        z_d         = z_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        out_valid_d = out_valid_q;
        odata_d     = odata_q;

        // z is undone first because encryption updated it last.
        z_new_s = z_q - tea_mix(y_q, key_q[63:32], key_q[31:0], sum_q);
        y_new_s = y_q - tea_mix(z_new_s, key_q[127:96], key_q[95:64], sum_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    y_d     = bus.idata[63:32];
                    z_d     = bus.idata[31:0];
                    key_d   = bus.key;
                    sum_d   = SUM_INIT;
                    cnt_d   = CNT_INIT;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                y_d   = y_new_s;
                z_d   = z_new_s;
                sum_d = sum_q - DELTA;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    odata_d     = {y_new_s, z_new_s};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= 32'h0;
            z_q         <= 32'h0;
            sum_q       <= 32'h0;
            cnt_q       <= '0;
            key_q       <= 128'h0;
            out_valid_q <= 1'b0;
            odata_q     <= 64'h0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            z_q         <= z_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            odata_q     <= odata_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.odata     = odata_q;

endmodule

// File: tb/tb_tea_decrypt_iter.sv
// Self-checking bench for tea_decrypt_iter: known vector, encrypt/decrypt round-trip,
// backpressure, busy rejection, mid-run reset and a single-round instance.
module tb_tea_decrypt_iter;

    localparam logic [31:0] DELTA = 32'h9E37_79B9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tea_decrypt_iter_if b32 ();
    tea_decrypt_iter_if b1 ();

    tea_decrypt_iter #(.ROUNDS(32), .DELTA(DELTA)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    tea_decrypt_iter #(.ROUNDS(1), .DELTA(DELTA)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] ka,
                                        input logic [31:0] kb, input logic [31:0] s);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // Reference TEA encryption chain, round i uses sum = DELTA*i.
    function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k, input int n);
        logic [31:0] y, z, s;
        y = p[63:32];
        z = p[31:0];
        s = 32'h0;
        for (int i = 1; i <= n; i++) begin
            s = s + DELTA;
            y = y + mix(z, k[127:96], k[95:64], s);
            z = z + mix(y, k[63:32], k[31:0], s);
        end
        return {y, z};
    endfunction

    typedef struct {
        logic [63:0]  ct;
        logic [127:0] key;
        logic [63:0]  pt;
    } vec_t;

    vec_t vecs[6];

    task automatic accept32(input logic [63:0] ct, input logic [127:0] k);
        @(negedge clk);
        check("in_ready_before_accept", 64'(b32.in_ready), 64'd1);
        b32.in_valid = 1'b1;
        b32.idata    = ct;
        b32.key      = k;
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        b32.idata    = {$urandom, $urandom};
        b32.key      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out32(output int lat, output logic busy_bad);
        lat      = 0;
        busy_bad = 1'b0;
        while (b32.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (b32.in_ready !== 1'b0) busy_bad = 1'b1;
        end
    endtask

    task automatic run32(input logic [63:0] ct, input logic [127:0] k, input logic [63:0] pt);
        int   lat;
        logic busy_bad;
        b32.out_ready = 1'b1;
        accept32(ct, k);
        wait_out32(lat, busy_bad);
        check("latency", 64'(lat), 64'd32);
        check("in_ready_low_busy", 64'(busy_bad), 64'd0);
        check("odata", b32.odata, pt);
        @(posedge clk);
        #1;
        check("out_valid_drop", 64'(b32.out_valid), 64'd0);
        check("in_ready_back", 64'(b32.in_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        logic        busy_bad;
        logic        bad;
        logic [63:0] hold;
        logic [63:0] pt;
        logic [127:0] k;

        rst_n         = 1'b0;
        b32.in_valid  = 1'b0;
        b32.idata     = 64'h0;
        b32.key       = 128'h0;
        b32.out_ready = 1'b1;
        b1.in_valid   = 1'b0;
        b1.idata      = 64'h0;
        b1.key        = 128'h0;
        b1.out_ready  = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_odata", b32.odata, 64'h0);
        rst_n = 1'b1;

        vecs[0] = '{ct: 64'h41EA3A0A_94BAA940, key: 128'h0, pt: 64'h0};
        vecs[1] = '{ct: 64'h0, key: 128'h00112233_44556677_8899AABB_CCDDEEFF, pt: 64'h01234567_89ABCDEF};
        vecs[2] = '{ct: 64'h0, key: {128{1'b1}}, pt: {64{1'b1}}};
        vecs[3] = '{ct: 64'h0, key: {128{1'b1}}, pt: 64'h0};
        vecs[4] = '{ct: 64'h0, key: 128'h80000000_00000001_80000000_00000001, pt: 64'h80000000_00000001};
        vecs[5] = '{ct: 64'h0, key: 128'h0, pt: 64'hDEADBEEF_CAFEF00D};
        for (int i = 1; i < 6; i++) vecs[i].ct = tea_enc(vecs[i].pt, vecs[i].key, 32);

        for (int i = 0; i < 6; i++) run32(vecs[i].ct, vecs[i].key, vecs[i].pt);

        // Round-trip against the reference encryption chain.
        for (int i = 0; i < 1000; i++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            run32(tea_enc(pt, k, 32), k, pt);
        end

        // Backpressure: output must hold while out_ready is low.
        b32.out_ready = 1'b0;
        accept32(vecs[1].ct, vecs[1].key);
        wait_out32(lat, busy_bad);
        check("bp_latency", 64'(lat), 64'd32);
        check("bp_odata", b32.odata, vecs[1].pt);
        hold = b32.odata;
        bad  = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (b32.odata !== hold || b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0) bad = 1'b1;
        end
        check("bp_stable", 64'(bad), 64'd0);
        @(negedge clk);
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_out_valid_drop", 64'(b32.out_valid), 64'd0);
        check("bp_in_ready", 64'(b32.in_ready), 64'd1);

        // Busy rejection: a second block offered during RUN is dropped.
        accept32(vecs[2].ct, vecs[2].key);
        fork
            begin
                repeat (3) @(negedge clk);
                b32.in_valid = 1'b1;
                b32.idata    = vecs[4].ct;
                b32.key      = vecs[4].key;
                @(negedge clk);
                b32.in_valid = 1'b0;
            end
        join_none
        wait_out32(lat, busy_bad);
        check("busy_latency", 64'(lat), 64'd32);
        check("busy_odata", b32.odata, vecs[2].pt);
        check("busy_in_ready_low", 64'(busy_bad), 64'd0);
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) bad = 1'b1;
        end
        check("busy_no_second", 64'(bad), 64'd0);

        // Reset during round 10.
        accept32(vecs[5].ct, vecs[5].key);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(b32.out_valid), 64'd0);
        check("midrst_odata", b32.odata, 64'h0);
        check("midrst_in_ready", 64'(b32.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run32(vecs[3].ct, vecs[3].key, vecs[3].pt);

        // Single-round instance.
        for (int i = 0; i < 4; i++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("r1_in_ready", 64'(b1.in_ready), 64'd1);
            b1.in_valid = 1'b1;
            b1.idata    = tea_enc(pt, k, 1);
            b1.key      = k;
            @(posedge clk);
            #1;
            b1.in_valid = 1'b0;
            check("r1_not_yet", 64'(b1.out_valid), 64'd0);
            @(posedge clk);
            #1;
            check("r1_out_valid", 64'(b1.out_valid), 64'd1);
            check("r1_odata", b1.odata, pt);
            @(posedge clk);
            #1;
            check("r1_out_valid_drop", 64'(b1.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
